// File: rtl/periferico_pwm_multi.sv
// periferico_pwm_multi: N-channel PWM with prescaler, polarity, shadowed period/duty and wrap interrupt.
module periferico_pwm_multi #(
    parameter int NCH = 2,
    parameter int CW  = 16,
    parameter int PW  = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [31:0]     d_in,
    input  logic [7:0]      addr,
    input  logic            wr,
    input  logic            rd,
    output logic [31:0]     d_out,
    output logic [NCH-1:0]  pwm_out,
    output logic            irq
);
    logic [NCH-1:0] wrap, ie, sel, status;
    logic [31:0]    rv [NCH];
    logic [31:0]    rdata;
    logic           st_hit;
    assign st_hit = addr == 8'hF0;
    for (genvar c = 0; c < NCH; c++) begin : g_ch
        logic          en, pol, ien, pwm, tick, ctrl_wr;
        logic [PW-1:0] pre, pcnt;
        logic [CW-1:0] per, duty, aper, aduty, cnt, per_nxt, duty_nxt;
        assign sel[c]   = addr[1:0] == 2'b00 && addr[7:4] == 4'(c);
        assign ctrl_wr  = wr && sel[c] && addr[3:2] == 2'd0;
        assign per_nxt  = wr && sel[c] && addr[3:2] == 2'd1 ? d_in[CW-1:0] : per;
        assign duty_nxt = wr && sel[c] && addr[3:2] == 2'd2 ? d_in[CW-1:0] : duty;
        assign tick     = en && pcnt == pre;
        // PERIOD of 0 or 1 wraps on every tick
        assign wrap[c]  = tick && (aper <= CW'(1) || cnt >= aper - CW'(1));
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                en    <= 1'b0;
                pol   <= 1'b0;
                ien   <= 1'b0;
                pre   <= '0;
                pcnt  <= '0;
                per   <= '0;
                duty  <= '0;
                aper  <= '0;
                aduty <= '0;
                cnt   <= '0;
                pwm   <= 1'b0;
            end else begin
                if (ctrl_wr) begin
                    en  <= d_in[0];
                    pol <= d_in[1];
                    ien <= d_in[2];
                    pre <= d_in[8 +: PW];
                end
                per  <= per_nxt;
                duty <= duty_nxt;
                if (!en) begin
                    pcnt  <= '0;
                    cnt   <= '0;
                    aper  <= per_nxt;
                    aduty <= duty_nxt;
                end else begin
                    pcnt <= tick ? '0 : pcnt + PW'(1);
                    if (wrap[c]) begin
                        cnt   <= '0;
                        aper  <= per;
                        aduty <= duty;
                    end else if (tick) begin
                        cnt <= cnt + CW'(1);
                    end
                end
                pwm <= en ? (cnt < aduty) ^ pol : pol;
            end
        end
        assign ie[c]      = ien;
        assign pwm_out[c] = pwm;
        assign rv[c] = addr[3:2] == 2'd0 ? 32'({pre, 5'b0, ien, pol, en}) :
                       addr[3:2] == 2'd1 ? 32'(per) :
                       addr[3:2] == 2'd2 ? 32'(duty) : 32'(cnt);
    end
    always_comb begin
        rdata = st_hit ? 32'(status) : '0;
        for (int i = 0; i < NCH; i++) rdata = rdata | (sel[i] ? rv[i] : '0);
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            status <= '0;
            irq    <= 1'b0;
            d_out  <= '0;
        end else begin
            status <= (status & ~(wr && st_hit ? d_in[NCH-1:0] : '0)) | wrap;
            irq    <= |(status & ie);
            if (rd) d_out <= rdata;
        end
    end
endmodule

// File: tb/tb_periferico_pwm_multi.sv
// tb_periferico_pwm_multi: directed register-level checks of the 2-channel PWM peripheral.
module tb_periferico_pwm_multi;
    logic        clk = 1'b0, rst_n = 1'b0, wr = 1'b0, rd = 1'b0;
    logic [31:0] d_in = '0;
    logic [7:0]  addr = '0;
    logic [31:0] d_out;
    logic [1:0]  pwm_out;
    logic        irq;
    int          errors = 0, checks = 0, hi;
    logic [19:0] pat;

    periferico_pwm_multi dut (
        .clk(clk), .rst_n(rst_n), .d_in(d_in), .addr(addr), .wr(wr), .rd(rd),
        .d_out(d_out), .pwm_out(pwm_out), .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic write_reg(input logic [7:0] a, input logic [31:0] d);
        addr = a; d_in = d; wr = 1'b1;
        @(negedge clk);
        wr = 1'b0;
    endtask

    task automatic read_reg(input logic [7:0] a);
        addr = a; rd = 1'b1;
        @(negedge clk);
        rd = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        @(negedge clk);
        addr = 8'h00; d_in = '1; rd = 1'b1;
        for (int i = 0; i < 3; i++) begin
            wr = ~wr;
            @(negedge clk);
        end
        check("rst pwm", 32'(pwm_out), 0);
        check("rst irq", 32'(irq), 0);
        check("rst d_out", d_out, 0);
        rst_n = 1'b1; wr = 1'b0; rd = 1'b0;
        read_reg(8'h00); check("rst ctrl", d_out, 0);
        read_reg(8'h04); check("rst period", d_out, 0);
        read_reg(8'hF0); check("rst status", d_out, 0);

        write_reg(8'h04, 10);
        write_reg(8'h08, 3);
        write_reg(8'h00, 32'h1);
        addr = 8'hF0; rd = 1'b1;
        pat = 20'b1110000000_1110000000;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            check("ch0 pwm", 32'(pwm_out[0]), 32'(pat[19-k]));
            check("ch0 wrap", 32'(d_out[0]), 32'(k >= 10));
        end
        rd = 1'b0;

        write_reg(8'h14, 200);
        write_reg(8'h18, 10);
        write_reg(8'h10, 32'h0403);
        addr = 8'h1C; rd = 1'b1;
        for (int k = 1; k <= 1001; k++) begin
            @(negedge clk);
            if (k == 1 || k == 5 || k == 6 || k == 51 || k == 1000 || k == 1001)
                check("ch1 count", d_out, 32'(((k - 1) / 5) % 200));
            if (k == 50 || k == 51 || k == 1000 || k == 1001)
                check("ch1 pwm", 32'(pwm_out[1]), 32'(k == 51 || k == 1000));
        end
        rd = 1'b0;
        repeat (20) @(negedge clk);
        write_reg(8'h10, 32'h0402);
        check("ch1 pre-dis", 32'(pwm_out[1]), 0);
        @(negedge clk);
        check("ch1 dis pol", 32'(pwm_out[1]), 1);
        read_reg(8'h1C); check("ch1 dis count", d_out, 0);

        write_reg(8'h00, 32'h0);
        write_reg(8'h00, 32'h1);
        pat = 20'b1110000000_1111111100;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            check("shadow pwm", 32'(pwm_out[0]), 32'(pat[19-k]));
            if (k == 4) begin addr = 8'h08; d_in = 8; wr = 1'b1; end
            if (k == 5) wr = 1'b0;
        end
        write_reg(8'h08, 0);
        repeat (15) @(negedge clk);
        hi = 0;
        for (int k = 0; k < 10; k++) begin @(negedge clk); hi += int'(pwm_out[0]); end
        check("duty0", 32'(hi), 0);
        write_reg(8'h08, 12);
        repeat (15) @(negedge clk);
        hi = 0;
        for (int k = 0; k < 10; k++) begin @(negedge clk); hi += int'(pwm_out[0]); end
        check("duty12", 32'(hi), 10);

        write_reg(8'h00, 32'h0);
        write_reg(8'hF0, 32'h3);
        write_reg(8'h00, 32'h5);
        for (int k = 1; k <= 11; k++) begin
            @(negedge clk);
            check("irq wait", 32'(irq), 32'(k == 11));
        end
        write_reg(8'hF0, 32'h1);
        check("irq hold", 32'(irq), 1);
        @(negedge clk);
        check("irq clr", 32'(irq), 0);
        repeat (6) @(negedge clk);
        write_reg(8'hF0, 32'h1);
        read_reg(8'hF0);
        check("w1c set wins", 32'(d_out[0]), 1);
        check("irq set wins", 32'(irq), 1);

        addr = 8'h04; d_in = 77; wr = 1'b1; rd = 1'b1;
        @(negedge clk);
        wr = 1'b0; rd = 1'b0;
        check("rw same old", d_out, 10);
        read_reg(8'h04); check("rw same new", d_out, 77);
        read_reg(8'h30); check("unmapped ch", d_out, 0);
        write_reg(8'h10, 32'hFFFF_FFF8);
        read_reg(8'h10); check("ctrl unused", d_out, 32'h0000_FF00);
        write_reg(8'h1C, 123);
        read_reg(8'h1C); check("count ro", d_out, 0);
        read_reg(8'h00); check("ch0 ctrl", d_out, 32'h5);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/periferico_pwm_multi.md
Name: periferico_pwm_multi

Overview:
- Parametrised N-channel PWM peripheral; successor to the fixed two-channel PWM block on the LM32 bus side.
- Same simple register interface as its predecessor: d_in/addr/wr/rd.
- Adds per-channel prescaler, output polarity, shadow (glitch-free) period/duty update at period wrap, counter read-back, and a sticky wrap-interrupt status.

Parameters:
- NCH, 2, number of PWM channels (1..15).
- CW, 16, width of period/duty/counter registers (1..32).
- PW, 8, prescaler width.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  synchronous active-low reset.
- d_in  in  32  write data.
- addr  in  8  byte address.
- wr  in  1  write strobe, sampled each cycle.
- rd  in  1  read strobe, sampled each cycle.
- d_out  out  32  read data.
- pwm_out  out  NCH  PWM outputs; bit ch = channel ch.
- irq  out  1  interrupt request.

Behaviour:
- Register map, channel ch at base ch*0x10:
  - +0x0 CTRL: bit0 EN, bit1 POL (invert), bit2 IE, bits[8+PW-1:8] PRE.
  - +0x4 PERIOD (shadow).
  - +0x8 DUTY (shadow).
  - +0xC COUNT (read-only; writes ignored).
- 0xF0 STATUS: bit ch = wrap flag; write-1-to-clear.
- Any other address: writes ignored, reads return 0. Channel bases at or above NCH are unmapped.
- Reset (rst_n=0 at a clk edge): all CTRL/shadow/active/counter/prescaler/STATUS regs = 0, d_out = 0, pwm_out = 0, irq = 0. Reset mid-period aborts immediately.
- Write: wr=1 stores d_in at that edge. PERIOD/DUTY keep d_in[CW-1:0]; unused CTRL bits are not stored and read as 0.
- Read: rd=1 puts the register on d_out at the next edge (1-cycle latency); values are zero-extended. d_out holds its value while rd=0.
  - rd and wr to the same address in one cycle: d_out returns the pre-write value.
- Prescaler: while EN=1, pcnt counts 0..PRE; tick = (pcnt==PRE). PRE=0 gives a tick every cycle.
- Counter: on tick, if cnt >= act_period-1 then cnt<=0, act_period<=PERIOD, act_duty<=DUTY, and STATUS[ch] is set (wrap). Otherwise cnt<=cnt+1.
- Disable: EN=0 forces pcnt=0 and cnt=0; active regs track shadow every cycle (writes take effect immediately).
- Enable (EN 0->1): counting starts from cnt=0 with the active values captured while disabled. The first tick occurs PRE+1 cycles after the EN write edge.
- PERIOD=0 or 1 (active): cnt stays 0, a wrap occurs on every tick, and shadow values load every tick.
- Output, registered: raw = (cnt < act_duty).
  - pwm_out[ch] = EN ? raw^POL : POL.
  - DUTY=0 gives constant inactive; DUTY>=PERIOD gives constant active.
  - Output changes one cycle after the cnt change.
- Mid-period PERIOD/DUTY writes while enabled never alter the current period; they apply from the cycle after the wrap.
- STATUS: a set from wrap and a W1C clear in the same cycle resolve to set wins.
- irq = OR over ch of (STATUS[ch] & IE[ch]), registered (1 cycle after the STATUS change).
- Counter arithmetic is CW-bit unsigned; cnt never exceeds act_period-1.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles with wr=1 toggling -> all outputs 0; reads of 0x0/0x4/0xF0 return 0 after release.
- Ch0 basic: PERIOD=10, DUTY=3, CTRL=0x1 -> pwm_out[0] high 3 cycles, low 7 cycles, repeating with period 10; STATUS[0] sets every 10 cycles.
- Ch1 with POL and prescale: CTRL=0x0403 (PRE=4, POL, EN), PERIOD=200, DUTY=10 -> pwm_out[1] low 50 cycles, high 950 cycles; COUNT read at 0x1C advances once every 5 cycles.
- Shadow update: ch0 running PERIOD=10, DUTY=3; write DUTY=8 at cnt=5 -> current period stays 3-high; next period is 8-high. Edge cases: DUTY=0 -> constant low; DUTY=12 -> constant high.
- Interrupt: IE=1 on ch0, wait for wrap -> irq=1; write 0x1 to 0xF0 -> irq=0 two cycles later. W1C issued on a wrap cycle -> STATUS stays 1.
- Read path: read 0x4 while writing 0x4 in the same cycle -> d_out shows the old value next cycle. Read 0x30 with NCH=2 -> 0. Disable mid-period -> pwm_out equals POL next cycle and COUNT reads 0.
